// File: rtl/cpu_defs.sv
// Shared CPU definitions.
// Register address type and scoreboard depth limit.
package cpu_defs;

    typedef logic [4:0] reg_addr_t;

    localparam int NUM_REGS        = 32;
    localparam int SB_MAX_INFLIGHT = 4;

endpackage

// File: rtl/sb_counter.sv
// Saturating up/down counter for one architectural register.
// Flush clears it; over/underflow raise a one-cycle error pulse.
module sb_counter #(
    parameter int MAX = 4,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         i_inc,
    input  logic         i_dec,
    input  logic         i_flush,
    output logic [W-1:0] o_cnt,
    output logic         o_busy,
    output logic         o_err
);

    localparam logic [W-1:0] LP_MAX = W'(MAX);

    logic [W-1:0] r_cnt;
    logic [W-1:0] w_cnt_nxt;
    logic         w_ovf;
    logic         w_udf;

    // next count: flush wins, paired inc/dec cancel, limits hold the value
    always_comb begin
        w_ovf     = i_inc && !i_dec && (r_cnt == LP_MAX);
        w_udf     = i_dec && !i_inc && (r_cnt == '0);
        w_cnt_nxt = r_cnt;
        if (i_flush) begin
            w_cnt_nxt = '0;
        end else if (i_inc && !i_dec && !w_ovf) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end else if (i_dec && !i_inc && !w_udf) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end
    end

    // counter register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_busy = (r_cnt != '0);
    assign o_err  = !i_flush && (w_ovf || w_udf);

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks outstanding writes per GPR
// and raises a decode stall on RAW hazards.
module reg_scoreboard
    import cpu_defs::*;
#(
    parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT,
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic      clk,
    input  logic      resetn,
    input  logic      issue_fire,
    input  logic      issue_we,
    input  reg_addr_t issue_dest,
    input  reg_addr_t rs_addr,
    input  reg_addr_t rt_addr,
    input  logic      rs_used,
    input  logic      rt_used,
    input  logic      ds_valid,
    input  logic      retire_we,
    input  reg_addr_t retire_dest,
    input  logic      flush,
    output logic      rs_busy,
    output logic      rt_busy,
    output logic      sb_stall,
    output logic [2:0] inflight_total,
    output logic      sb_error
);

    logic                 w_inc_ev;
    logic                 w_dec_ev;
    logic [NUM_REGS-1:0]  w_busy;
    logic [NUM_REGS-1:0]  w_err;
    logic [CNT_W-1:0]     w_cnt [NUM_REGS];
    logic [5:0]           w_nz;
    logic                 r_sb_error;

    assign w_inc_ev = issue_fire && issue_we && (issue_dest != '0);
    assign w_dec_ev = retire_we && (retire_dest != '0);

    // $0 is hardwired: never counted, never busy
    assign w_busy[0] = 1'b0;
    assign w_err[0]  = 1'b0;
    assign w_cnt[0]  = '0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
        sb_counter #(
            .MAX (MAX_INFLIGHT),
            .W   (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .resetn  (resetn),
            .i_inc   (w_inc_ev && (issue_dest == reg_addr_t'(g))),
            .i_dec   (w_dec_ev && (retire_dest == reg_addr_t'(g))),
            .i_flush (flush),
            .o_cnt   (w_cnt[g]),
            .o_busy  (w_busy[g]),
            .o_err   (w_err[g])
        );
    end

    // number of registers with writes outstanding
    always_comb begin
        w_nz = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            w_nz = w_nz + {5'b0, w_busy[i]};
        end
    end

    // sticky error; only reset clears it
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sb_error <= 1'b0;
        end else if (|w_err) begin
            r_sb_error <= 1'b1;
        end
    end

    assign rs_busy        = w_busy[rs_addr];
    assign rt_busy        = w_busy[rt_addr];
    assign sb_stall       = ds_valid && ((rs_used && rs_busy) ||
                                         (rt_used && rt_busy));
    assign inflight_total = (w_nz > 6'd7) ? 3'd7 : w_nz[2:0];
    assign sb_error       = r_sb_error;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard.
// Directed scenarios plus random traffic against a reference model.
module tb_reg_scoreboard;

    import cpu_defs::*;

    localparam int MAXI = 4;

    logic       clk = 1'b0;
    logic       resetn;
    logic       issue_fire, issue_we, retire_we, flush;
    logic [4:0] issue_dest, retire_dest, rs_addr, rt_addr;
    logic       rs_used, rt_used, ds_valid;
    logic       rs_busy, rt_busy, sb_stall, sb_error;
    logic [2:0] inflight_total;

    int n_tot = 0;
    int n_bad = 0;

    int m_cnt [32];
    bit m_err;

    logic       s_rs_busy, s_rt_busy, s_stall, s_err;
    logic [2:0] s_total;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk            (clk),
        .resetn         (resetn),
        .issue_fire     (issue_fire),
        .issue_we       (issue_we),
        .issue_dest     (issue_dest),
        .rs_addr        (rs_addr),
        .rt_addr        (rt_addr),
        .rs_used        (rs_used),
        .rt_used        (rt_used),
        .ds_valid       (ds_valid),
        .retire_we      (retire_we),
        .retire_dest    (retire_dest),
        .flush          (flush),
        .rs_busy        (rs_busy),
        .rt_busy        (rt_busy),
        .sb_stall       (sb_stall),
        .inflight_total (inflight_total),
        .sb_error       (sb_error)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int m_total();
        int n = 0;
        for (int i = 1; i < 32; i++) if (m_cnt[i] != 0) n++;
        return (n > 7) ? 7 : n;
    endfunction

    function automatic bit m_busy(input logic [4:0] a);
        return (a != 0) && (m_cnt[a] != 0);
    endfunction

    // apply the scoreboard rules for one clock edge
    task automatic m_edge();
        bit inc, dec;
        if (!resetn) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_err = 0;
            return;
        end
        if (flush) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            return;
        end
        inc = issue_fire && issue_we && issue_dest != 0;
        dec = retire_we && retire_dest != 0;
        if (inc && dec && issue_dest == retire_dest) return;
        if (inc) begin
            if (m_cnt[issue_dest] == MAXI) m_err = 1;
            else m_cnt[issue_dest]++;
        end
        if (dec) begin
            if (m_cnt[retire_dest] == 0) m_err = 1;
            else m_cnt[retire_dest]--;
        end
    endtask

    // compare outputs mid-cycle, then advance model across the edge
    task automatic cycle();
        bit e_rs, e_rt, e_st;
        @(negedge clk);
        e_rs = m_busy(rs_addr);
        e_rt = m_busy(rt_addr);
        e_st = ds_valid && ((rs_used && e_rs) || (rt_used && e_rt));
        s_rs_busy = rs_busy;
        s_rt_busy = rt_busy;
        s_stall   = sb_stall;
        s_total   = inflight_total;
        s_err     = sb_error;
        check("rs_busy", 32'(rs_busy), 32'(e_rs));
        check("rt_busy", 32'(rt_busy), 32'(e_rt));
        check("sb_stall", 32'(sb_stall), 32'(e_st));
        check("inflight", 32'(inflight_total), 32'(m_total()));
        check("sb_error", 32'(sb_error), 32'(m_err));
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic idle();
        issue_fire = 0; issue_we = 0; issue_dest = 0;
        retire_we = 0; retire_dest = 0; flush = 0;
    endtask

    task automatic iss(input logic [4:0] d);
        issue_fire = 1; issue_we = 1; issue_dest = d;
    endtask

    task automatic ret(input logic [4:0] d);
        retire_we = 1; retire_dest = d;
    endtask

    task automatic do_reset();
        resetn = 0;
        idle();
        cycle();
        resetn = 1;
    endtask

    initial begin
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_err = 0;
        resetn = 0;
        idle();
        rs_addr = 0; rt_addr = 0;
        rs_used = 0; rt_used = 0; ds_valid = 0;
        @(posedge clk);
        #1;
        do_reset();

        // reset state
        rs_addr = 5; rt_addr = 9; rs_used = 1; rt_used = 1; ds_valid = 1;
        cycle();
        check("rst_rs", 32'(s_rs_busy), 0);
        check("rst_stall", 32'(s_stall), 0);
        check("rst_total", 32'(s_total), 0);
        check("rst_err", 32'(s_err), 0);
        rt_used = 0;

        // issue $5, then a reader of $5 stalls
        iss(5); cycle(); idle();
        cycle();
        check("s34_busy", 32'(s_rs_busy), 1);
        check("s34_stall", 32'(s_stall), 1);
        check("s34_total", 32'(s_total), 1);

        // three writes of $7 outstanding, retired one at a time
        rs_addr = 7;
        for (int i = 0; i < 3; i++) begin iss(7); cycle(); end
        idle();
        for (int i = 0; i < 3; i++) begin
            ret(7); cycle();
            check("s35_busy", 32'(s_rs_busy), 1);
        end
        idle();
        cycle();
        check("s35_clear", 32'(s_rs_busy), 0);
        check("s35_err", 32'(s_err), 0);

        // same-cycle issue and retire of $9
        rt_addr = 9; rt_used = 1;
        iss(9); cycle();
        iss(9); ret(9); cycle(); idle();
        cycle();
        check("s36_rt", 32'(s_rt_busy), 1);

        // flush beats a same-cycle issue
        do_reset();
        rs_addr = 3; rt_addr = 4;
        iss(3); cycle(); cycle(); iss(4); cycle();
        idle(); iss(3); flush = 1; cycle(); idle();
        cycle();
        check("s37_rs", 32'(s_rs_busy), 0);
        check("s37_rt", 32'(s_rt_busy), 0);
        check("s37_total", 32'(s_total), 0);
        check("s37_err", 32'(s_err), 0);

        // underflow is sticky; overflow saturates
        ret(12); cycle(); idle();
        cycle();
        check("s38_udf", 32'(s_err), 1);
        rs_addr = 2;
        for (int i = 0; i < 5; i++) begin iss(2); cycle(); end
        idle();
        cycle();
        check("s38_sat", 32'(s_err), 1);
        check("s38_busy", 32'(s_rs_busy), 1);
        for (int i = 0; i < 4; i++) begin ret(2); cycle(); end
        idle();
        cycle();
        check("s38_drain", 32'(s_rs_busy), 0);

        // $0 never becomes busy
        do_reset();
        rs_addr = 0; rs_used = 1; ds_valid = 1;
        iss(0); cycle(); idle();
        cycle();
        check("s39_busy", 32'(s_rs_busy), 0);
        check("s39_stall", 32'(s_stall), 0);
        check("s39_total", 32'(s_total), 0);

        // random traffic on a small register window to force collisions
        for (int n = 0; n < 3000; n++) begin
            resetn      = ($urandom_range(0, 59) != 0);
            issue_fire  = $urandom_range(0, 1);
            issue_we    = ($urandom_range(0, 3) != 0);
            issue_dest  = 5'($urandom_range(0, 9));
            retire_we   = $urandom_range(0, 1);
            retire_dest = 5'($urandom_range(0, 9));
            flush       = ($urandom_range(0, 29) == 0);
            rs_addr     = 5'($urandom_range(0, 11));
            rt_addr     = 5'($urandom_range(0, 31));
            rs_used     = $urandom_range(0, 1);
            rt_used     = $urandom_range(0, 1);
            ds_valid    = $urandom_range(0, 1);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Interface
REQ-001 Parameter MAX_INFLIGHT, default 4, maximum outstanding writes to one architectural register (ES, PMS, MS, WS).
REQ-002 Parameter CNT_W, default 3, per-register counter width; SHALL satisfy 2^CNT_W > MAX_INFLIGHT.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 resetn  in  1  reset, synchronous and active-low.
REQ-005 issue_fire  in  1  ID-to-EXE transfer this cycle (ds_to_es_valid && es_allowin).
REQ-006 issue_we  in  1  issued instruction writes the register file.
REQ-007 issue_dest  in  5  destination of issued instruction.
REQ-008 rs_addr, rt_addr  in  5 each  source registers of the instruction in ID.
REQ-009 rs_used, rt_used  in  1 each  instruction in ID reads rs / rt.
REQ-010 ds_valid  in  1  ID holds a valid instruction.
REQ-011 retire_we  in  1  WB register-file write this cycle.
REQ-012 retire_dest  in  5  WB write address.
REQ-013 flush  in  1  exception or ERET pipeline flush (pipeline_flush.ex | pipeline_flush.eret).
REQ-014 rs_busy, rt_busy  out  1 each  source has at least one outstanding write.
REQ-015 sb_stall  out  1  ds_valid && ((rs_used && rs_busy) || (rt_used && rt_busy)).
REQ-016 inflight_total  out  3  number of registers with a nonzero counter, saturating at 7.
REQ-017 sb_error  out  1  sticky flag set on counter overflow or underflow.

Function
REQ-018 The block SHALL hold one CNT_W-bit counter per register 1..31; register 0 SHALL never count and SHALL always read not-busy.
REQ-019 Increment event: issue_fire && issue_we && issue_dest != 0 increments cnt[issue_dest] at the next edge.
REQ-020 Decrement event: retire_we && retire_dest != 0 decrements cnt[retire_dest] at the next edge.
REQ-021 Increment and decrement of the same register in one cycle SHALL leave that counter unchanged; events on different registers SHALL both apply.
REQ-022 rs_busy and rt_busy SHALL be combinational from the registered counters (cnt != 0), with zero-cycle latency and no issue-to-busy bypass; an instruction issued in cycle N makes its destination busy from cycle N+1.
REQ-023 A retire in cycle N SHALL clear busy in cycle N+1 only; the WB forward path covers cycle N.
REQ-024 Overflow: an increment while cnt == MAX_INFLIGHT SHALL leave the counter unchanged and set sb_error.
REQ-025 Underflow: a decrement while cnt == 0 SHALL leave the counter at 0 and set sb_error.
REQ-026 flush SHALL clear every counter at the next edge and override same-cycle increment and decrement events; sb_error SHALL be unaffected.
REQ-027 inflight_total SHALL be computed from the registered counters.
REQ-028 sb_stall SHALL be 0 whenever ds_valid == 0.

Reset
REQ-029 With resetn == 0 at a posedge, all counters SHALL be 0 and sb_error SHALL be 0; all other inputs are ignored that cycle.
REQ-030 After reset, rs_busy, rt_busy, sb_stall, inflight_total and sb_error SHALL all be 0.
REQ-031 Reset asserted mid-operation SHALL discard all outstanding counts without generating an error.

Structure
REQ-032 reg_addr_t (5-bit) and SB_MAX_INFLIGHT SHALL live in the shared cpu_defs package; CNT_W SHALL be derived locally.
REQ-033 One sub-module, sb_counter, SHALL implement a single saturating up/down counter with flush and an error pulse; reg_scoreboard SHALL instantiate 31 copies and OR the error pulses into sb_error.

Verification
REQ-034 Reset, then issue $5 (fire, we, dest=5) -> next cycle rs_addr=5, rs_used=1, ds_valid=1 gives rs_busy=1, sb_stall=1, inflight_total=1.
REQ-035 Issue $7 three times on consecutive cycles, then three retires of $7 -> busy stays 1 until the cycle after the third retire, then 0, sb_error=0.
REQ-036 In one cycle, issue dest=9 and retire dest=9 with cnt[9]=1 -> cnt[9] remains 1 and rt_busy (rt_addr=9) stays 1.
REQ-037 cnt[3]=2 and cnt[4]=1, then flush together with issue dest=3 -> next cycle all busy outputs are 0, inflight_total=0, sb_error=0.
REQ-038 Retire dest=12 with cnt[12]=0 -> sb_error=1 and stays 1 until resetn=0; five issues of $2 -> cnt[2] saturates at 4 and sb_error=1.
REQ-039 Issue dest=0 and rs_addr=0 with rs_used=1 -> rs_busy=0, sb_stall=0, inflight_total unchanged.
